// File: rtl/prefetch1k_pkg.sv
// Shared constants, state encoding and width helpers for the 1 KiB prefetch read master.
package prefetch1k_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  localparam int DEF_BURST_LEN      = 16;
  localparam int DEF_PREFETCH_WORDS = 256;

  // Counter width for n distinct values; never below one bit so BURST_LEN=1 still elaborates.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int BEAT_W  = width_of(DEF_BURST_LEN);
  localparam int BURST_W = width_of(DEF_PREFETCH_WORDS / DEF_BURST_LEN);
  localparam int IDX_W   = width_of(DEF_PREFETCH_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/prefetch1k_read_master_if.sv
// AXI4 read address and read data channels between the prefetch master and the interconnect.
// A transfer on either channel happens on a rising edge where VALID and READY are both high;
// VALID, once raised, holds its payload stable until that edge, and READY may depend on VALID.
interface prefetch1k_read_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] ARADDR;
  logic [7:0]        ARLEN;
  logic [2:0]        ARSIZE;
  logic [1:0]        ARBURST;
  logic              ARVALID;
  logic              ARREADY;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;
  logic              RVALID;
  logic              RREADY;

  modport master (
    output ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    input  ARREADY, RDATA, RRESP, RLAST, RVALID
  );

  modport slave (
    input  ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    output ARREADY, RDATA, RRESP, RLAST, RVALID
  );
endinterface

// File: rtl/prefetch1k_buf_ram.sv
// Simple dual-port prefetch buffer: write port fed by the R channel, registered read port
// for the consumer. A same-address read and write returns the previous contents.
module prefetch1k_buf_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int DW    = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rdata_q <= '0;
    else         rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/prefetch1k_read_master.sv
// Prefetches PREFETCH_WORDS words from an aligned base address with one-at-a-time AXI4 INCR
// bursts into a local buffer, then pulses ap_done back to the control slave.
module prefetch1k_read_master
  import prefetch1k_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int BURST_LEN          = DEF_BURST_LEN,
  parameter int PREFETCH_WORDS     = DEF_PREFETCH_WORDS
) (
  input  logic                                  ACLK,
  input  logic                                  ARESETN,
  input  logic                                  ap_start,
  input  logic [31:0]                           a,
  input  logic                                  addrs_flag,
  output logic                                  ap_done,
  output logic                                  ap_idle,
  output logic                                  rd_err,
  output logic                                  buf_valid,
  prefetch1k_read_master_if.master              m_axi,
  input  logic [width_of(PREFETCH_WORDS)-1:0]   buf_raddr,
  output logic [C_M_AXI_DATA_WIDTH-1:0]         buf_rdata,
  output state_e                                dbg_state_o
);

  localparam int NUM_BURSTS  = PREFETCH_WORDS / BURST_LEN;
  localparam int BEAT_CW     = width_of(BURST_LEN);
  localparam int BURST_CW    = width_of(NUM_BURSTS);
  localparam int IDX_CW      = width_of(PREFETCH_WORDS);
  localparam int BURST_BYTES = BURST_LEN * 4;
  localparam int ALIGN_W     = $clog2(BURST_BYTES);

  localparam logic [BEAT_CW-1:0]  LAST_BEAT  = BEAT_CW'(BURST_LEN - 1);
  localparam logic [BURST_CW-1:0] LAST_BURST = BURST_CW'(NUM_BURSTS - 1);
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ALIGN_MASK = ~C_M_AXI_ADDR_WIDTH'(BURST_BYTES - 1);

  state_e                        state_q, state_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0] base_q, base_d;
  logic [BURST_CW-1:0]           burst_idx_q, burst_idx_d;
  logic [BEAT_CW-1:0]            beat_cnt_q, beat_cnt_d;
  logic                          rd_err_q, rd_err_d;
  logic                          buf_valid_q, buf_valid_d;

  logic              beat_fire;
  logic              last_beat;
  logic [IDX_CW-1:0] wr_idx;

  assign beat_fire = m_axi.RVALID && m_axi.RREADY;
  assign last_beat = (beat_cnt_q == LAST_BEAT);
  assign wr_idx    = IDX_CW'(burst_idx_q) * IDX_CW'(BURST_LEN) + IDX_CW'(beat_cnt_q);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      burst_idx_q <= '0;
      beat_cnt_q  <= '0;
      rd_err_q    <= 1'b0;
      buf_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      burst_idx_q <= burst_idx_d;
      beat_cnt_q  <= beat_cnt_d;
      rd_err_q    <= rd_err_d;
      buf_valid_q <= buf_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    burst_idx_d = burst_idx_q;
    beat_cnt_d  = beat_cnt_q;
    rd_err_d    = rd_err_q;
    buf_valid_d = buf_valid_q;

    unique case (state_q)
      ST_IDLE: begin
        if (ap_start) begin
          base_d      = C_M_AXI_ADDR_WIDTH'(a) & ALIGN_MASK;
          burst_idx_d = '0;
          beat_cnt_d  = '0;
          rd_err_d    = 1'b0;
          buf_valid_d = 1'b0;
          state_d     = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (m_axi.ARREADY) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (beat_fire) begin
          // Beat counting alone ends a burst; RLAST is only checked for consistency.
          if ((m_axi.RRESP != RESP_OKAY) || (m_axi.RLAST != last_beat)) rd_err_d = 1'b1;
          if (last_beat) begin
            beat_cnt_d  = '0;
            burst_idx_d = burst_idx_q + BURST_CW'(1);
            state_d     = (burst_idx_q == LAST_BURST) ? ST_DONE : ST_ADDR;
          end else begin
            beat_cnt_d  = beat_cnt_q + BEAT_CW'(1);
          end
        end
      end
      ST_DONE: begin
        buf_valid_d = ~rd_err_q;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A new software address always invalidates, even against a completing fetch.
    if (addrs_flag) buf_valid_d = 1'b0;
  end

  assign m_axi.ARADDR  = base_q + (C_M_AXI_ADDR_WIDTH'(burst_idx_q) << ALIGN_W);
  assign m_axi.ARLEN   = 8'(BURST_LEN - 1);
  assign m_axi.ARSIZE  = SIZE_4B;
  assign m_axi.ARBURST = BURST_INCR;
  assign m_axi.ARVALID = (state_q == ST_ADDR);
  assign m_axi.RREADY  = (state_q == ST_DATA);

  assign ap_done     = (state_q == ST_DONE);
  assign ap_idle     = (state_q == ST_IDLE);
  assign rd_err      = rd_err_q;
  assign buf_valid   = buf_valid_q;
  assign dbg_state_o = state_q;

  prefetch1k_buf_ram #(
    .DEPTH (PREFETCH_WORDS),
    .AW    (IDX_CW),
    .DW    (C_M_AXI_DATA_WIDTH)
  ) u_buf_ram (
    .clk_i   (ACLK),
    .rst_ni  (ARESETN),
    .we_i    (beat_fire),
    .waddr_i (wr_idx),
    .wdata_i (m_axi.RDATA),
    .raddr_i (buf_raddr),
    .rdata_o (buf_rdata)
  );

endmodule

// File: tb/tb_prefetch1k_read_master.sv
// Directed bench for prefetch1k_read_master: AXI read slave model returning data = address,
// burst-address scoreboard, buffer read-back, error, invalidation and mid-transfer reset cases.
module tb_prefetch1k_read_master;
  import prefetch1k_pkg::*;

  // ---------------- clock / reset ----------------
  logic ACLK = 1'b0;
  logic ARESETN;
  initial forever #5 ACLK = ~ACLK;

  logic        ap_start, addrs_flag;
  logic [31:0] a;
  logic        ap_done, ap_idle, rd_err, buf_valid;
  logic [7:0]  buf_raddr;
  logic [31:0] buf_rdata;
  state_e      dbg_state;

  prefetch1k_read_master_if #(.ADDR_W(32), .DATA_W(32)) axi ();

  prefetch1k_read_master dut (
    .ACLK        (ACLK),
    .ARESETN     (ARESETN),
    .ap_start    (ap_start),
    .a           (a),
    .addrs_flag  (addrs_flag),
    .ap_done     (ap_done),
    .ap_idle     (ap_idle),
    .rd_err      (rd_err),
    .buf_valid   (buf_valid),
    .m_axi       (axi),
    .buf_raddr   (buf_raddr),
    .buf_rdata   (buf_rdata),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int vectors     = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];
  logic [31:0] buf_exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    vectors++;
    assert (got === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, expv);
    end
  endtask

  // ---------------- AXI read slave model ----------------
  bit gap_en    = 1'b0;
  int err_burst = -1, err_beat = -1;
  int rl_burst  = -1, rl_beat  = -1;
  int flush_seq = 0;
  bit          have;
  logic [31:0] cur_addr;
  int          beat, burst_cnt;

  initial begin
    int flush_ack;
    bit ar_hs, r_hs, stalled;
    logic [31:0] ar_addr;
    logic [7:0]  ar_len;
    flush_ack   = 0;
    have        = 1'b0;
    cur_addr    = '0;
    beat        = 0;
    burst_cnt   = 0;
    axi.ARREADY = 1'b0;
    axi.RVALID  = 1'b0;
    axi.RDATA   = '0;
    axi.RRESP   = 2'b00;
    axi.RLAST   = 1'b0;
    forever begin
      @(negedge ACLK);
      ar_hs   = axi.ARVALID && axi.ARREADY;
      r_hs    = axi.RVALID && axi.RREADY;
      stalled = axi.ARVALID && !axi.ARREADY;
      ar_addr = axi.ARADDR;
      ar_len  = axi.ARLEN;
      @(posedge ACLK);
      #1;
      if (ar_hs) begin
        if (exp_q.size() == 0) chk("ar_extra_burst", 32'(exp_q.size()), 32'd1);
        else                   chk("araddr", ar_addr, exp_q.pop_front());
        chk("arlen", 32'(ar_len), 32'd15);
        have     = 1'b1;
        cur_addr = ar_addr;
        beat     = 0;
      end
      if (r_hs) begin
        beat++;
        if (beat == 16) begin
          have = 1'b0;
          burst_cnt++;
        end
      end
      if (stalled && axi.ARVALID) chk("araddr_stable", axi.ARADDR, ar_addr);
      if (flush_seq != flush_ack) begin
        flush_ack  = flush_seq;
        have       = 1'b0;
        beat       = 0;
        burst_cnt  = 0;
        axi.RVALID = 1'b0;
      end
      if (!(axi.RVALID && !r_hs)) begin
        axi.RVALID = have && (gap_en ? ($urandom_range(0, 1) == 1) : 1'b1);
        axi.RDATA  = cur_addr + 32'(beat * 4);
        axi.RRESP  = (burst_cnt == err_burst && beat == err_beat) ? 2'b10 : 2'b00;
        axi.RLAST  = (beat == 15) || (burst_cnt == rl_burst && beat == rl_beat);
      end
      axi.ARREADY = gap_en ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic setup_run(input logic [31:0] addr, input bit gaps, input int eb, input int ebeat,
                           input int lb, input int lbeat);
    logic [31:0] base;
    base      = addr & 32'hFFFF_FFC0;
    gap_en    = gaps;
    err_burst = eb;
    err_beat  = ebeat;
    rl_burst  = lb;
    rl_beat   = lbeat;
    flush_seq++;
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(base + 32'(i * 64));
    @(posedge ACLK);
    #1;
    @(posedge ACLK);
    #1;
    a        = addr;
    ap_start = 1'b1;
    @(posedge ACLK);
    #1;
    ap_start = 1'b0;
  endtask

  task automatic run_fetch(input string tag, input logic [31:0] addr, input bit gaps,
                           input int eb, input int ebeat, input int lb, input int lbeat,
                           input bit flag_done, input bit poke, input bit exp_err);
    logic [31:0] base;
    int done_cnt, post;
    base = addr & 32'hFFFF_FFC0;
    setup_run(addr, gaps, eb, ebeat, lb, lbeat);
    chk({tag, "_arvalid_rise"}, 32'(axi.ARVALID), 32'd1);
    chk({tag, "_start_clr_err"}, 32'(rd_err), 32'd0);
    chk({tag, "_start_clr_valid"}, 32'(buf_valid), 32'd0);
    done_cnt = 0;
    post     = 0;
    for (int c = 0; c < 3000; c++) begin
      if (poke && c == 40) begin
        a        = 32'h2000_0000;
        ap_start = 1'b1;
      end else begin
        ap_start = 1'b0;
      end
      if (ap_done) begin
        done_cnt++;
        addrs_flag = flag_done;
      end else begin
        addrs_flag = 1'b0;
      end
      if (done_cnt > 0) post++;
      if (post > 6) break;
      @(posedge ACLK);
      #1;
    end
    ap_start   = 1'b0;
    addrs_flag = 1'b0;
    chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    chk({tag, "_rd_err"}, 32'(rd_err), 32'(exp_err));
    chk({tag, "_buf_valid"}, 32'(buf_valid), 32'(!exp_err && !flag_done));
    chk({tag, "_idle"}, 32'(ap_idle), 32'd1);
    chk({tag, "_bursts_left"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_bursts_done"}, 32'(burst_cnt), 32'd16);
    if (!exp_err) begin
      for (int i = 0; i < 256; i++) begin
        buf_raddr = 8'(i);
        buf_exp_q.push_back(base + 32'(i * 4));
        @(posedge ACLK);
        #1;
        chk({tag, "_buf"}, buf_rdata, buf_exp_q.pop_front());
      end
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit found;
    ARESETN    = 1'b0;
    ap_start   = 1'b0;
    a          = '0;
    addrs_flag = 1'b0;
    buf_raddr  = '0;
    repeat (3) @(posedge ACLK);
    #1;
    chk("rst_ap_done", 32'(ap_done), 32'd0);
    chk("rst_ap_idle", 32'(ap_idle), 32'd1);
    chk("rst_rd_err", 32'(rd_err), 32'd0);
    chk("rst_buf_valid", 32'(buf_valid), 32'd0);
    chk("rst_arvalid", 32'(axi.ARVALID), 32'd0);
    chk("rst_rready", 32'(axi.RREADY), 32'd0);
    chk("rst_araddr", axi.ARADDR, 32'd0);
    chk("rst_arlen", 32'(axi.ARLEN), 32'd15);
    chk("rst_arsize", 32'(axi.ARSIZE), 32'd2);
    chk("rst_arburst", 32'(axi.ARBURST), 32'd1);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge ACLK);
    ARESETN = 1'b1;

    run_fetch("norm",  32'h1000_0000, 1'b0, -1, -1, -1, -1, 1'b0, 1'b0, 1'b0);
    run_fetch("unal",  32'h1000_0013, 1'b0, -1, -1, -1, -1, 1'b0, 1'b0, 1'b0);
    run_fetch("bp",    32'h1000_0000, 1'b1, -1, -1, -1, -1, 1'b0, 1'b1, 1'b0);
    run_fetch("rresp", 32'h1000_0000, 1'b0,  3,  5, -1, -1, 1'b0, 1'b0, 1'b1);
    run_fetch("clean", 32'h1000_0440, 1'b0, -1, -1, -1, -1, 1'b0, 1'b0, 1'b0);

    addrs_flag = 1'b1;
    @(posedge ACLK);
    #1;
    addrs_flag = 1'b0;
    chk("idle_flag_invalidate", 32'(buf_valid), 32'd0);

    run_fetch("rlast", 32'h1000_0000, 1'b0, -1, -1,  0, 14, 1'b0, 1'b0, 1'b1);
    run_fetch("flag",  32'h1000_0000, 1'b0, -1, -1, -1, -1, 1'b1, 1'b0, 1'b0);
    run_fetch("wrap",  32'hFFFF_FE40, 1'b0, -1, -1, -1, -1, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of burst 7, beat 3.
    setup_run(32'h3000_0000, 1'b0, -1, -1, -1, -1);
    found = 1'b0;
    for (int c = 0; c < 2000 && !found; c++) begin
      @(negedge ACLK);
      #1;
      if (have && burst_cnt == 7 && beat == 3) found = 1'b1;
    end
    chk("rst_mid_trigger", 32'(found), 32'd1);
    chk("rst_mid_rready_before", 32'(axi.RREADY), 32'd1);
    ARESETN = 1'b0;
    #1;
    chk("rst_mid_arvalid", 32'(axi.ARVALID), 32'd0);
    chk("rst_mid_rready", 32'(axi.RREADY), 32'd0);
    chk("rst_mid_idle", 32'(ap_idle), 32'd1);
    flush_seq++;
    exp_q.delete();
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    ARESETN = 1'b1;
    run_fetch("after_rst", 32'h3000_0000, 1'b0, -1, -1, -1, -1, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/prefetch1k_read_master.md
Name: prefetch1k_read_master

Overview:
Downstream consumer of the AXI-Lite control slave. Takes the slave's ap_start pulse and 32-bit start address `a`, and issues AXI4 INCR read bursts to prefetch PREFETCH_WORDS 32-bit words (1 KiB by default) into a local buffer. Signals completion back to the slave through ap_done. Exposes the buffer through a synchronous read port for the compute datapath.

Parameters:
C_M_AXI_ADDR_WIDTH, 32, AXI read address width.
C_M_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
BURST_LEN, 16, beats per burst; power of two, 1..256.
PREFETCH_WORDS, 256, words fetched per start; power of two and a multiple of BURST_LEN.

Ports:
ACLK  in  1  clock
ARESETN  in  1  asynchronous active-low reset
ap_start  in  1  one-cycle start pulse from the control slave
a  in  32  prefetch start byte address
addrs_flag  in  1  pulses when software writes a new address; invalidates the buffer
ap_done  out  1  one-cycle completion pulse to the control slave
ap_idle  out  1  high in IDLE
rd_err  out  1  sticky error: RRESP not OKAY, or RLAST misplaced
buf_valid  out  1  buffer holds a complete, error-free prefetch
M_AXI_ARADDR  out  C_M_AXI_ADDR_WIDTH  burst address
M_AXI_ARLEN  out  8  BURST_LEN-1
M_AXI_ARSIZE  out  3  3'b010
M_AXI_ARBURST  out  2  2'b01 (INCR)
M_AXI_ARVALID  out  1  address valid
M_AXI_ARREADY  in  1  address ready
M_AXI_RDATA  in  32  read data
M_AXI_RRESP  in  2  read response
M_AXI_RLAST  in  1  last beat
M_AXI_RVALID  in  1  data valid
M_AXI_RREADY  out  1  data ready
buf_raddr  in  log2(PREFETCH_WORDS)  consumer word index
buf_rdata  out  32  buffer word; 1-cycle read latency

Behaviour:
- Clock and reset: single clock ACLK. ARESETN is asynchronous, active-low. Every flop, except the buffer RAM contents, is cleared on reset.
- Reset values: ap_done=0, ap_idle=1, rd_err=0, buf_valid=0, ARVALID=0, RREADY=0, ARADDR=0. ARLEN, ARSIZE and ARBURST are constants.
- State machine: IDLE -> ADDR -> DATA -> (ADDR | DONE) -> IDLE.
- IDLE:
  - On ap_start=1: latch base = {a[31:6+], 6'b0}, i.e. `a` aligned down to BURST_LEN*4 bytes, so no burst crosses a 4 KiB boundary.
  - Same cycle: clear burst_idx, beat_cnt, rd_err and buf_valid; go to ADDR.
- IDLE timing: ARVALID rises the cycle after ap_start is sampled. ap_start outside IDLE is ignored.
- ADDR:
  - ARVALID=1, ARADDR = base + burst_idx*BURST_LEN*4; the address is held stable until the handshake.
  - On ARVALID&ARREADY: go to DATA. Only one burst is outstanding at a time.
- DATA:
  - RREADY=1. Each RVALID&RREADY beat writes RDATA to buffer[burst_idx*BURST_LEN + beat_cnt] and increments beat_cnt.
  - On the beat where beat_cnt == BURST_LEN-1: clear beat_cnt and increment burst_idx. If that was the last burst, go to DONE; otherwise go to ADDR.
- DONE: one cycle. ap_done=1. buf_valid <= ~rd_err. Then go to IDLE.
- Error handling:
  - RRESP != 2'b00 on any beat sets rd_err.
  - RLAST=1 on a beat other than BURST_LEN-1 sets rd_err; so does RLAST=0 on beat BURST_LEN-1.
  - Beat counting alone defines burst end. The transfer always runs to completion; ap_done still pulses.
- addrs_flag: clears buf_valid in any state.
  - If addrs_flag and the DONE-cycle buf_valid set coincide, addrs_flag wins (buf_valid=0).
  - addrs_flag does not abort an active transfer.
- Buffer: buf_rdata = buffer[buf_raddr] registered, one cycle after the address is presented.
  - If a buffer write and a consumer read hit the same address in the same cycle, the old data is returned.
  - Consumer reads during a transfer are permitted; data is valid only while buf_valid=1.
- Arithmetic: all index and address sums wrap modulo their width. A base near 0xFFFF_FC00 wraps ARADDR without special handling.
- Reset during a transfer: ARVALID and RREADY drop immediately and the machine returns to IDLE. The interconnect shares the same reset, so the dropped handshake is acceptable.

Decomposition:
- Shared package prefetch1k_pkg holds:
  - AXI constants: BURST_INCR=2'b01, SIZE_4B=3'b010, RESP_OKAY=2'b00.
  - State encoding: IDLE, ADDR, DATA, DONE.
  - Derived widths: BEAT_W, BURST_W, IDX_W via $clog2.
- One sub-module, prefetch1k_buf_ram: simple dual-port RAM, PREFETCH_WORDS x 32.
  - Write port: AXI R channel. Read port: consumer, registered output, inferred as BRAM.

Test Plan:
- Normal transfer: a=0x1000_0000, ap_start pulse, ARREADY and RVALID always high, RDATA = address.
  - Expect 16 bursts at 0x1000_0000, +0x40, ... +0x3C0, each with ARLEN=15.
  - Expect ap_done one pulse, buf_valid=1, buffer[255]=0x1000_03FC.
- Unaligned start: a=0x1000_0013 -> first ARADDR=0x1000_0000.
- Back-pressure: random ARREADY and RVALID gaps (about 50%).
  - ARADDR must stay stable while ARVALID=1 and ARREADY=0.
  - Buffer contents must match the normal-transfer case; ap_done pulses exactly once.
- Error response: RRESP=2'b10 on beat 5 of burst 3.
  - All 256 beats are still accepted; ap_done pulses; rd_err=1; buf_valid=0.
  - A following clean ap_start clears rd_err and ends with buf_valid=1.
- Misplaced RLAST and invalidation:
  - RLAST on beat 14 of burst 0 -> rd_err=1.
  - addrs_flag pulsed in the same cycle as DONE -> buf_valid stays 0.
- Reset mid-transfer: ARESETN low during burst 7 beat 3.
  - ARVALID=0, RREADY=0, ap_idle=1 immediately, before the next clock edge.
  - After release, a new ap_start runs a full 16-burst fetch.
